eth_tx_fcs_ctrl: RTL and testbench



---
 rtl/eth_tx_fcs_ctrl_if.sv | 23 ++
 rtl/eth_tx_fcs_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_eth_tx_fcs_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_fcs_ctrl_if.sv
// Upstream body nibble stream into the MII TX framer.
// master: producer drives in_valid/in_data/in_last and reads in_ready.
// slave: framer reads the stream and drives in_ready.
interface eth_tx_fcs_ctrl_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/eth_tx_fcs_ctrl.sv
// MII TX framer: preamble/SFD, body, zero pad, FCS, inter-frame gap.
// Ports: clk, rst (sync, active-high); up (slave nibble stream);
// crc_clr/crc_en/crc_din drive an external nibble crc32, crc_data is
// its registered result; tx_en/tx_data/tx_er are registered MII TX;
// busy is high outside IDLE; frame_done pulses on IFG entry after FCS.
module eth_tx_fcs_ctrl #(
  parameter int MIN_NIBBLES = 120,
  parameter int IFG_NIBBLES = 24,
  parameter int CNT_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  eth_tx_fcs_ctrl_if.slave  up,
  output logic              crc_clr,
  output logic              crc_en,
  output logic [3:0]        crc_din,
  input  logic [31:0]       crc_data,
  output logic              tx_en,
  output logic [3:0]        tx_data,
  output logic              tx_er,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    BODY,
    PAD,
    FCS,
    DROP,
    IFG
  } state_t;

  localparam logic [CNT_W:0] MIN_C =
    (CNT_W+1)'(MIN_NIBBLES);
  localparam logic [CNT_W:0] IFG_C =
    (CNT_W+1)'(IFG_NIBBLES);
  localparam logic [CNT_W:0] ONE_C =
    (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] SFD_C =
    CNT_W'(15);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   cnt_p1;
  logic [2:0]       idx;
  logic [2:0]       idx_d;
  logic             en_d;
  logic             er_d;
  logic             done_d;
  logic [3:0]       dat_d;
  logic [31:0]      crc_sh;
  logic [3:0]       fcs_nib;

  // cnt_p1 is one bit wider so length compares see the true cnt+1
  assign cnt_p1  = {1'b0, cnt} + ONE_C;
  assign cnt_inc = (&cnt) ? cnt : cnt_p1[CNT_W-1:0];

  // FCS goes out complemented, register MSB first, bit 0 of each
  // nibble leaving first on the wire
  assign crc_sh  = crc_data << {idx, 2'b00};
  assign fcs_nib = ~{crc_sh[28], crc_sh[29],
                     crc_sh[30], crc_sh[31]};

  assign busy = (state != IDLE);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    en_d        = 1'b0;
    er_d        = 1'b0;
    done_d      = 1'b0;
    dat_d       = 4'h0;
    up.in_ready = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_din     = 4'h0;
    unique case (state)
      IDLE: begin
        if (up.in_valid) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        crc_clr = 1'b1;
        en_d    = 1'b1;
        dat_d   = (cnt == SFD_C) ? 4'hD : 4'h5;
        cnt_d   = cnt_inc;
        if (cnt == SFD_C) begin
          state_d = BODY;
          cnt_d   = '0;
        end
      end
      BODY: begin
        up.in_ready = 1'b1;
        en_d        = 1'b1;
        if (up.in_valid) begin
          crc_en  = 1'b1;
          crc_din = up.in_data;
          dat_d   = up.in_data;
          cnt_d   = cnt_inc;
          if (up.in_last) begin
            idx_d   = '0;
            state_d = (cnt_p1 < MIN_C) ? PAD : FCS;
          end
        end else begin
          // underrun: flag the wire once, then
          // swallow the rest of the body
          er_d    = 1'b1;
          state_d = DROP;
        end
      end
      PAD: begin
        crc_en = 1'b1;
        en_d   = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_p1 >= MIN_C) begin
          idx_d   = '0;
          state_d = FCS;
        end
      end
      FCS: begin
        en_d  = 1'b1;
        dat_d = fcs_nib;
        idx_d = idx + 3'd1;
        if (idx == 3'd7) begin
          state_d = IFG;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      DROP: begin
        up.in_ready = 1'b1;
        if (up.in_valid && up.in_last) begin
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      IFG: begin
        cnt_d = cnt_inc;
        if (cnt_p1 >= IFG_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // reset holds the engine cleared and
    // keeps clr/en exclusive
    if (rst) begin
      crc_clr     = 1'b1;
      crc_en      = 1'b0;
      up.in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      tx_en      <= 1'b0;
      tx_data    <= 4'h0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      tx_en      <= en_d;
      tx_data    <= dat_d;
      tx_er      <= er_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Directed bench for eth_tx_fcs_ctrl with a nibble crc32 model.
// dut_a runs without padding, dut_b with default parameters.
module tb_eth_tx_fcs_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_tx_fcs_ctrl_if ua ();
  eth_tx_fcs_ctrl_if ub ();

  logic        a_clr, a_en, a_txen, a_er;
  logic        a_busy, a_done;
  logic [3:0]  a_din, a_txd;
  logic [31:0] a_crc;
  logic        b_clr, b_en, b_txen, b_er;
  logic        b_busy, b_done;
  logic [3:0]  b_din, b_txd;
  logic [31:0] b_crc;

  eth_tx_fcs_ctrl #(.MIN_NIBBLES(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .up         (ua),
    .crc_clr    (a_clr),
    .crc_en     (a_en),
    .crc_din    (a_din),
    .crc_data   (a_crc),
    .tx_en      (a_txen),
    .tx_data    (a_txd),
    .tx_er      (a_er),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  eth_tx_fcs_ctrl dut_b (
    .clk        (clk),
    .rst        (rst),
    .up         (ub),
    .crc_clr    (b_clr),
    .crc_en     (b_en),
    .crc_din    (b_din),
    .crc_data   (b_crc),
    .tx_en      (b_txen),
    .tx_data    (b_txd),
    .tx_er      (b_er),
    .busy       (b_busy),
    .frame_done (b_done)
  );

  // nibble-serial CRC-32 engine, data bit 0 first
  function automatic logic [31:0] crc_nib(
    input logic [31:0] r, input logic [3:0] d);
    logic [31:0] c;
    logic        fb;
    c = r;
    for (int k = 0; k < 4; k++) begin
      fb = c[31] ^ d[k];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (a_clr) a_crc <= '1;
    else if (a_en) a_crc <= crc_nib(a_crc, a_din);
    if (b_clr) b_crc <= '1;
    else if (b_en) b_crc <= crc_nib(b_crc, b_din);
  end

  // reference: standard reflected byte-wise CRC-32
  function automatic logic [31:0] ref_crc(
    input logic [7:0] b[$]);
    logic [31:0] c;
    c = '1;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  logic [4:0] a_dat[$];
  int         a_cyc[$];
  logic [4:0] b_dat[$];
  int         b_cyc[$];
  int a_nd = 0, a_ne = 0, b_nd = 0, b_ne = 0, ovl = 0;

  always @(negedge clk) begin
    if (a_txen) begin
      a_dat.push_back({a_er, a_txd});
      a_cyc.push_back(cyc);
    end
    if (b_txen) begin
      b_dat.push_back({b_er, b_txd});
      b_cyc.push_back(cyc);
    end
    if (a_done) a_nd <= a_nd + 1;
    if (a_er)   a_ne <= a_ne + 1;
    if (b_done) b_nd <= b_nd + 1;
    if (b_er)   b_ne <= b_ne + 1;
    if ((a_clr && a_en) || (b_clr && b_en))
      ovl <= ovl + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
    input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
        tag, o, e);
    end
  endtask

  logic [4:0] q[$];
  logic [7:0] bytes[$];
  logic [7:0] b2[$];
  int         req_cyc;

  task automatic add_frame(input logic [7:0] b[$]);
    foreach (b[i]) begin
      q.push_back({1'b0, b[i][3:0]});
      q.push_back({i == b.size() - 1, b[i][7:4]});
    end
  endtask

  task automatic put(input bit s, input logic v,
    input logic [4:0] e);
    if (s) begin
      ub.in_valid = v;
      ub.in_data  = e[3:0];
      ub.in_last  = e[4] & v;
    end else begin
      ua.in_valid = v;
      ua.in_data  = e[3:0];
      ua.in_last  = e[4] & v;
    end
  endtask

  task automatic send(input bit s, input int gap);
    int   i = 0;
    int   g = 0;
    int   n = q.size();
    bit   gapped = 0;
    bit   acc;
    logic v;
    v = 1'b1;
    put(s, v, q[0]);
    req_cyc = cyc;
    while (i < n && g < 4000) begin
      @(negedge clk);
      acc = (s ? ub.in_ready : ua.in_ready) && v;
      @(posedge clk);
      #1;
      g++;
      if (acc) i++;
      if (i == gap && !gapped) begin
        gapped = 1;
        v = 1'b0;
      end else begin
        v = (i < n);
      end
      if (v) put(s, 1'b1, q[i]);
      else   put(s, 1'b0, 5'h0);
    end
    chk("send_accepted", i, n);
    q.delete();
  endtask

  task automatic wait_idle(input bit s, output int t);
    int g = 0;
    @(negedge clk);
    while ((s ? b_busy : a_busy) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    t = cyc;
    chk("idle_reached", s ? b_busy : a_busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fcs_at(
    input bit s, input int base);
    logic [31:0] w;
    for (int k = 0; k < 8; k++)
      w[4*k +: 4] = s ? b_dat[base + k][3:0]
                      : a_dat[base + k][3:0];
    return w;
  endfunction

  initial begin
    string       s9;
    int          sa, sb, sd, se, t, bad;
    logic [3:0]  en;
    logic [7:0]  pad[$];

    put(0, 1'b0, 5'h0);
    put(1, 1'b0, 5'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clr", b_clr, 1'b1);
    chk("rst_en", b_en, 1'b0);
    chk("rst_outs",
      {b_txen, b_txd, b_er, b_done, b_busy, ub.in_ready},
      9'h0);
    chk("rst_outs_a",
      {a_txen, a_txd, a_er, a_done, a_busy, ua.in_ready},
      9'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // known CRC, no padding
    s9 = "123456789";
    bytes.delete();
    for (int i = 0; i < 9; i++) bytes.push_back(s9[i]);
    add_frame(bytes);
    sa = a_dat.size();
    sd = a_nd;
    se = a_ne;
    send(0, -1);
    wait_idle(0, t);
    chk("a_len", a_dat.size() - sa, 42);
    bad = 0;
    for (int k = 0; k < 15; k++)
      if (a_dat[sa + k] !== 5'h05) bad++;
    if (a_dat[sa + 15] !== 5'h0D) bad++;
    chk("a_preamble", bad, 0);
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      en = k[0] ? bytes[k/2][7:4] : bytes[k/2][3:0];
      if (a_dat[sa + 16 + k] !== {1'b0, en}) bad++;
    end
    chk("a_body", bad, 0);
    chk("a_fcs_known", fcs_at(0, sa + 34), 32'hCBF43926);
    chk("a_fcs_ref", fcs_at(0, sa + 34), ref_crc(bytes));
    chk("a_first_tx_en", a_cyc[sa] - req_cyc, 2);
    chk("a_contig", a_cyc[sa + 41] - a_cyc[sa], 41);
    chk("a_done", a_nd - sd, 1);
    chk("a_no_er", a_ne - se, 0);

    // short frame: 14 bytes padded to 60
    bytes.delete();
    for (int i = 0; i < 14; i++) bytes.push_back(8'(i*37 + 5));
    add_frame(bytes);
    sb = b_dat.size();
    sd = b_nd;
    send(1, -1);
    wait_idle(1, t);
    chk("short_len", b_dat.size() - sb, 144);
    bad = 0;
    for (int k = 44; k < 136; k++)
      if (b_dat[sb + k] !== 5'h00) bad++;
    chk("short_pad_zero", bad, 0);
    pad = bytes;
    while (pad.size() < 60) pad.push_back(8'h00);
    chk("short_fcs", fcs_at(1, sb + 136), ref_crc(pad));
    chk("short_done", b_nd - sd, 1);

    // exact minimum: no pad, FCS right after body
    bytes.delete();
    for (int i = 0; i < 60; i++) bytes.push_back(8'(i*11 + 1));
    add_frame(bytes);
    sb = b_dat.size();
    send(1, -1);
    wait_idle(1, t);
    chk("min_len", b_dat.size() - sb, 144);
    chk("min_last_body", b_dat[sb + 135],
      {1'b0, bytes[59][7:4]});
    chk("min_fcs", fcs_at(1, sb + 136), ref_crc(bytes));
    chk("min_contig", b_cyc[sb + 143] - b_cyc[sb], 143);
    chk("min_ifg", t - b_cyc[sb + 143], 24);

    // underrun after 40 body nibbles
    bytes.delete();
    for (int i = 0; i < 40; i++) bytes.push_back(8'(i + 100));
    add_frame(bytes);
    sb = b_dat.size();
    sd = b_nd;
    se = b_ne;
    send(1, 40);
    wait_idle(1, t);
    chk("ur_len", b_dat.size() - sb, 57);
    chk("ur_er_count", b_ne - se, 1);
    chk("ur_er_last", b_dat[sb + 56][4], 1'b1);
    chk("ur_no_done", b_nd - sd, 0);

    // back-to-back with in_valid held high
    bytes.delete();
    b2.delete();
    for (int i = 0; i < 64; i++) begin
      bytes.push_back(8'(i*7));
      b2.push_back(8'(i*13 + 9));
    end
    add_frame(bytes);
    add_frame(b2);
    sb = b_dat.size();
    sd = b_nd;
    send(1, -1);
    wait_idle(1, t);
    chk("b2b_len", b_dat.size() - sb, 304);
    chk("b2b_fcs1", fcs_at(1, sb + 144), ref_crc(bytes));
    chk("b2b_fcs2", fcs_at(1, sb + 296), ref_crc(b2));
    chk("b2b_gap",
      (b_cyc[sb + 152] - b_cyc[sb + 151]) >= 25, 1'b1);
    chk("b2b_done", b_nd - sd, 2);

    // reset during FCS nibble 3
    add_frame(bytes);
    sb = b_dat.size();
    sd = b_nd;
    send(1, -1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fcs_clr", b_clr, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_fcs_outs",
      {b_txen, b_txd, b_er, b_done, b_busy, ub.in_ready},
      9'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_fcs_len", b_dat.size() - sb, 147);
    chk("rst_fcs_no_done", b_nd - sd, 0);
    bytes.delete();
    for (int i = 0; i < 14; i++) bytes.push_back(8'(255 - i*3));
    add_frame(bytes);
    sb = b_dat.size();
    sd = b_nd;
    send(1, -1);
    wait_idle(1, t);
    pad = bytes;
    while (pad.size() < 60) pad.push_back(8'h00);
    chk("post_rst_fcs", fcs_at(1, sb + 136), ref_crc(pad));
    chk("post_rst_done", b_nd - sd, 1);
    chk("clr_en_excl", ovl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
